// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: PC mux selects, FSM states and pending redirect kinds.
// Optional redirect counters are enabled with FETCH_REDIRECT_CNT_EN.
package fetch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_4   = 2'b00,
        PC_ALU = 2'b01,
        PC_TGT = 2'b10,
        PC_RST = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        FR_BOOT  = 2'b00,
        FR_RUN   = 2'b01,
        FR_HOLD  = 2'b10,
        FR_FLUSH = 2'b11
    } fr_state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'b00,
        PEND_TGT  = 2'b01,
        PEND_MISP = 2'b10
    } pend_e;

endpackage

// File: rtl/fetch_redirect_ctrl_pending.sv
// Priority-merging pending redirect register: a mispredict overrides anything, a target-taken only fills an empty slot.
// Captures while stall is high; clear wins over capture.
module redirect_pending
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       br_mispred,
    input  logic       target_taken,
    input  logic       clear,
    output logic [1:0] pend
);

    pend_e pend_q;
    pend_e pend_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pend_d = pend_q;
        if (clear) begin
            pend_d = PEND_NONE;
        end else if (stall) begin
            if (br_mispred) begin
                pend_d = PEND_MISP;
            end else if (target_taken && (pend_q == PEND_NONE)) begin
                pend_d = PEND_TGT;
            end
        end
    end

    // NOTE: state flops use non-blocking assignment; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= PEND_NONE;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencing controller: boot hold, stall-deferred redirects and post-redirect IF/ID squash.
// Define FETCH_REDIRECT_CNT_EN to build the applied-redirect counters; otherwise they read as zero.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES  = 2,
    parameter int MISPRED_FLUSH = 2,
    parameter int TGT_FLUSH     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_mispred,
    input  logic        target_taken,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
    output logic        squash,
    output logic        fetch_valid,
    output logic [31:0] mispred_cnt,
    output logic [31:0] tgt_cnt
);

    localparam logic [3:0] BOOT_LEN = 4'(RESET_CYCLES);
    localparam logic [2:0] MISP_LEN = 3'(MISPRED_FLUSH);
    localparam logic [2:0] TGT_LEN  = 3'(TGT_FLUSH);

    fr_state_e  state_q, state_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [2:0] flush_load;
    pc_sel_e    sel;
    logic [1:0] pend_kind;
    logic       pend_capture, pend_clear, tt_eff;
    logic       apply_misp, apply_tgt;

    redirect_pending u_pending (
        .clk          (clk),
        .rst          (rst),
        .stall        (pend_capture),
        .br_mispred   (br_mispred),
        .target_taken (tt_eff),
        .clear        (pend_clear),
        .pend         (pend_kind)
    );

    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        flush_load   = 3'd0;
        sel          = PC_4;
        pc_en        = 1'b1;
        squash       = 1'b0;
        pend_capture = 1'b0;
        pend_clear   = 1'b0;
        tt_eff       = target_taken;
        apply_misp   = 1'b0;
        apply_tgt    = 1'b0;

        case (state_q)
            FR_BOOT: begin
                sel        = PC_RST;
                pend_clear = 1'b1;
                boot_cnt_d = boot_cnt_q - 4'd1;
                if (boot_cnt_q <= 4'd1) begin
                    state_d = FR_RUN;
                end
            end
            FR_RUN, FR_HOLD: begin
                if (stall) begin
                    pc_en        = 1'b0;
                    pend_capture = 1'b1;
                    state_d      = FR_HOLD;
                end else begin
                    pend_clear = 1'b1;
                    state_d    = FR_RUN;
                    if (br_mispred || (pend_e'(pend_kind) == PEND_MISP)) begin
                        apply_misp = 1'b1;
                    end else if (target_taken || (pend_e'(pend_kind) == PEND_TGT)) begin
                        apply_tgt = 1'b1;
                    end
                end
            end
            FR_FLUSH: begin
                // Target-taken here belongs to the squashed wrong path.
                squash = 1'b1;
                tt_eff = 1'b0;
                if (stall) begin
                    pc_en        = 1'b0;
                    pend_capture = 1'b1;
                end else begin
                    pend_clear = 1'b1;
                    if (br_mispred || (pend_e'(pend_kind) == PEND_MISP)) begin
                        apply_misp = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        if (flush_cnt_q <= 3'd1) begin
                            state_d = FR_RUN;
                        end
                    end
                end
            end
            default: state_d = FR_BOOT;
        endcase

        if (apply_misp || apply_tgt) begin
            squash     = 1'b1;
            sel        = apply_misp ? PC_ALU : PC_TGT;
            flush_load = apply_misp ? MISP_LEN : TGT_LEN;
            if (flush_load > 3'd1) begin
                state_d     = FR_FLUSH;
                flush_cnt_d = flush_load - 3'd1;
            end else begin
                state_d     = FR_RUN;
                flush_cnt_d = 3'd0;
            end
        end

        if (rst) begin
            sel        = PC_RST;
            pc_en      = 1'b1;
            squash     = 1'b0;
            apply_misp = 1'b0;
            apply_tgt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FR_BOOT;
            boot_cnt_q  <= BOOT_LEN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_sel      = sel;
    assign fetch_valid = !rst && !squash && (state_q != FR_BOOT) && pc_en;

`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] mispred_cnt_q, mispred_cnt_d;
    logic [31:0] tgt_cnt_q, tgt_cnt_d;

    always_comb begin
        mispred_cnt_d = mispred_cnt_q + (apply_misp ? 32'd1 : 32'd0);
        tgt_cnt_d     = tgt_cnt_q + (apply_tgt ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt_q <= 32'd0;
            tgt_cnt_q     <= 32'd0;
        end else begin
            mispred_cnt_q <= mispred_cnt_d;
            tgt_cnt_q     <= tgt_cnt_d;
        end
    end

    assign mispred_cnt = mispred_cnt_q;
    assign tgt_cnt     = tgt_cnt_q;
`else
    assign mispred_cnt = 32'd0;
    assign tgt_cnt     = 32'd0;
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencing controller for the RV32 fetch stage. Owns the PC mux select and PC write enable. Runs a post-reset boot-hold window, latches branch-mispredict and target-taken redirects that arrive under stall, and applies them when the stall clears. Issues a multi-cycle squash to the IF/ID pipeline registers after each redirect. Sits between the hazard/branch-resolution logic and the PC register / IMEM-BIOS fetch path.

## Interface
- RESET_CYCLES, 2: cycles PC is held at the reset vector after `rst` deasserts (memory priming); legal range 1..15.
- MISPRED_FLUSH, 2: squash cycles after an applied mispredict redirect; legal range 1..7.
- TGT_FLUSH, 1: squash cycles after an applied target-taken redirect; legal range 1..7.
- clk  in  1  core clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  backend stall; freezes PC.
- br_mispred  in  1  branch resolved mispredicted; redirect to ALU target.
- target_taken  in  1  predicted-taken target available; redirect to TGT.
- pc_sel  out  2  PC mux select: `PC_4`, `PC_ALU`, `PC_TGT`, `PC_RST`.
- pc_en  out  1  PC register write enable.
- squash  out  1  convert IF/ID contents to NOP this cycle.
- fetch_valid  out  1  fetched instruction is architecturally valid.
- mispred_cnt  out  32  applied mispredict redirects (feature-gated).
- tgt_cnt  out  32  applied target-taken redirects (feature-gated).

## Operation
- States: BOOT, RUN, HOLD, FLUSH. A pending register holds one of NONE / TGT / MISP.
- Priority everywhere: `br_mispred` > `target_taken`.
- **Reset** (`rst`=1): state BOOT, boot counter = RESET_CYCLES, pending = NONE, flush counter = 0, counters = 0.
  - Outputs while in reset: pc_sel=`PC_RST`, pc_en=1, squash=0, fetch_valid=0.
- **BOOT**: pc_sel=`PC_RST`, pc_en=1, fetch_valid=0. Counter decrements each cycle. Redirect inputs and `stall` are ignored. At count 1, go to RUN.
- **RUN, stall=0, redirect asserted**: pc_sel=`PC_ALU` or `PC_TGT` combinationally in the same cycle, pc_en=1, squash=1. The flush counter loads MISPRED_FLUSH or TGT_FLUSH.
  - If the loaded value > 1, go to FLUSH with remaining = value−1. Otherwise stay in RUN.
  - The matching counter increments.
- **RUN, stall=0, no redirect**: pc_sel=`PC_4`, pc_en=1, squash=0, fetch_valid=1.
- **RUN, stall=1**: pc_en=0, pc_sel=`PC_4`. Any redirect is latched into pending. Go to HOLD.
- **HOLD, stall=1**: pc_en=0. MISP overwrites a pending TGT or NONE. TGT overwrites only NONE.
- **HOLD, stall=0**: the effective redirect is the higher priority of pending and the same-cycle inputs.
  - It is applied exactly as in RUN (same-cycle pc_sel, squash, flush load, counter increment).
  - pending clears. With no redirect, return to RUN with pc_sel=`PC_4`.
- **FLUSH**: squash=1, fetch_valid=0, pc_sel=`PC_4`, pc_en=!stall.
  - The counter decrements only when stall=0. Go to RUN when it reaches 0.
  - `target_taken` is ignored (wrong path).
  - `br_mispred` with stall=0 is applied immediately and reloads the counter.
  - `br_mispred` with stall=1 is latched as MISP and applied in the first cycle stall=0.
- fetch_valid = !squash && state∉{BOOT} && pc_en.
- `rst` in any state, including mid-FLUSH or HOLD, aborts to BOOT and drops pending.

## Timing
- Redirect to PC select: 0 cycles (combinational from inputs and state). The PC updates on the next edge.
- Stall-deferred redirect: applied in the first cycle stall=0. The PC updates at the following edge.
- Total squash cycles per redirect = MISPRED_FLUSH or TGT_FLUSH, not counting stalled cycles.
- pending, state, and counters are registered. All counter increments occur at the edge ending the apply cycle.
- Counters wrap from 2^32−1 to 0.

## Configuration
- `FETCH_REDIRECT_CNT_EN` defined: mispred_cnt/tgt_cnt are live 32-bit registers as specified.
- Undefined: both outputs are tied to 32'd0, no counter flops are instantiated, and all other behaviour is identical.

## Structure
- `control_sel.vh` gains `PC_RST` (2'b11, distinct from `PC_4`/`PC_ALU`/`PC_TGT`), state encodings `FR_BOOT`/`FR_RUN`/`FR_HOLD`/`FR_FLUSH`, and pending encodings `PEND_NONE`/`PEND_TGT`/`PEND_MISP`.
- One sub-module, `redirect_pending`: the priority-merging pending register (inputs: stall, br_mispred, target_taken, clear; output: 2-bit pending kind).
- FSM, counters, and output decode stay in the top.

## Test plan
- Reset release, RESET_CYCLES=2: pc_sel=`PC_RST`, fetch_valid=0 for exactly 2 cycles after `rst` falls; cycle 3 gives pc_sel=`PC_4`, fetch_valid=1.
- RUN, br_mispred pulse 1 cycle, stall=0: same cycle pc_sel=`PC_ALU`, squash=1; squash=1 for one more cycle (MISPRED_FLUSH=2); mispred_cnt=1.
- stall=1 for 4 cycles, target_taken in cycle 1, br_mispred in cycle 3: pc_en=0 throughout; on stall release pc_sel=`PC_ALU` (not `PC_TGT`); tgt_cnt=0, mispred_cnt=1.
- FLUSH with stall=1 for 3 cycles: squash held, counter frozen; total squash cycles after release still equal MISPRED_FLUSH.
- target_taken during FLUSH: ignored, pc_sel=`PC_4`; br_mispred during FLUSH: immediate `PC_ALU`, flush restarts.
- `rst` asserted mid-HOLD with pending MISP: next cycle is BOOT, pc_sel=`PC_RST`; no `PC_ALU` is issued after boot completes; counters read 0 (macro defined) and 0 always (macro undefined).
